// File: rtl/edge_det_pkg.sv
// Shared types and constants for the multi-channel edge detector.
package edge_det_pkg;

  // Per-channel edge selection, two bits per channel on the top-level bus.
  typedef logic [1:0] edge_mode_t;

  localparam edge_mode_t MODE_OFF  = 2'b00;
  localparam edge_mode_t MODE_RISE = 2'b01;
  localparam edge_mode_t MODE_FALL = 2'b10;
  localparam edge_mode_t MODE_BOTH = 2'b11;

endpackage

// File: rtl/edge_filter_ch.sv
// One channel: synchroniser chain, consecutive-sample debounce filter,
// filtered level and mode-qualified edge pulse. The qualified edge is also
// exported one cycle early (hit) so the parent can update its sticky flags
// in the same cycle the registered pulse appears.
module edge_filter_ch
  import edge_det_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       raw,
  input  edge_mode_t mode,
  output logic       hit,
  output logic       level,
  output logic       pulse
);

  localparam int CNT_W = $clog2(FILT_LEN + 1);

  logic [SYNC_STAGES-1:0] sync_p0;
  logic [CNT_W-1:0]       cnt_p1;
  logic                   s;
  logic                   toggle;

  // Decide whether a level change in the given direction is reported.
  function automatic logic qualify(input edge_mode_t m, input logic rising);
    logic q;
    case (m)
      MODE_RISE: q = rising;
      MODE_FALL: q = ~rising;
      MODE_BOTH: q = 1'b1;
      default:   q = 1'b0;
    endcase
    return q;
  endfunction

  assign s      = sync_p0[SYNC_STAGES-1];
  assign toggle = (s != level) && (cnt_p1 == CNT_W'(FILT_LEN - 1));
  // Direction of the pending toggle is the inverse of the current level.
  assign hit    = toggle && qualify(mode, ~level);

  // Stage p0: metastability synchroniser, shifts the raw pin in.
  always_ff @(posedge clk) begin
    if (rst) sync_p0 <= '0;
    else     sync_p0 <= {sync_p0[SYNC_STAGES-2:0], raw};
  end

  // Stage p1: debounce counter, filtered level and registered edge pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_p1 <= '0;
      level  <= 1'b0;
      pulse  <= 1'b0;
    end else begin
      pulse <= hit;
      if (s == level) begin
        cnt_p1 <= '0;
      end else if (toggle) begin
        level  <= ~level;
        cnt_p1 <= '0;
      end else begin
        cnt_p1 <= cnt_p1 + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/edge_detector_multi.sv
// Multi-channel edge detector: per-channel filter instances plus the sticky
// pending/overrun flags and the registered any-pending summary.
module edge_detector_multi
  import edge_det_pkg::*;
#(
  parameter int CH          = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [CH-1:0]   i_signal,
  input  logic [2*CH-1:0] i_mode,
  input  logic [CH-1:0]   i_clear,
  output logic [CH-1:0]   o_level,
  output logic [CH-1:0]   o_edge,
  output logic [CH-1:0]   o_pending,
  output logic [CH-1:0]   o_overrun,
  output logic            o_any
);

  logic [CH-1:0] hit;

  for (genvar k = 0; k < CH; k++) begin : g_ch
    edge_filter_ch #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILT_LEN   (FILT_LEN)
    ) u_ch (
      .clk  (clk),
      .rst  (rst),
      .raw  (i_signal[k]),
      .mode (edge_mode_t'(i_mode[2*k +: 2])),
      .hit  (hit[k]),
      .level(o_level[k]),
      .pulse(o_edge[k])
    );
  end

  // Stage p2: sticky flags; a new edge beats a simultaneous clear for pending,
  // while a clear always wins for overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_pending <= '0;
      o_overrun <= '0;
    end else begin
      o_pending <= hit | (o_pending & ~i_clear);
      o_overrun <= (hit & o_pending & ~i_clear) | (o_overrun & ~i_clear);
    end
  end

  // Stage p3: registered summary, one cycle behind the pending flags.
  always_ff @(posedge clk) begin
    if (rst) o_any <= 1'b0;
    else     o_any <= |o_pending;
  end

endmodule

// File: tb/tb_edge_detector_multi.sv
// Directed self-checking bench for edge_detector_multi (default parameters).
module tb_edge_detector_multi;

  localparam int CH = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [CH-1:0]   i_signal;
  logic [2*CH-1:0] i_mode;
  logic [CH-1:0]   i_clear;
  logic [CH-1:0]   o_level;
  logic [CH-1:0]   o_edge;
  logic [CH-1:0]   o_pending;
  logic [CH-1:0]   o_overrun;
  logic            o_any;

  int n_checks = 0;
  int n_fail   = 0;

  edge_detector_multi #(.CH(CH), .SYNC_STAGES(2), .FILT_LEN(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .i_signal (i_signal),
    .i_mode   (i_mode),
    .i_clear  (i_clear),
    .o_level  (o_level),
    .o_edge   (o_edge),
    .o_pending(o_pending),
    .o_overrun(o_overrun),
    .o_any    (o_any)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs and checks both happen 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int first_idx;
  int second_idx;
  int npulse;

  initial begin
    rst      = 1'b1;
    i_signal = '0;
    i_clear  = '0;
    // ch0 rise, ch1 both, ch2 fall, ch3 rise, ch4 rise, others off
    i_mode   = 16'h016D;
    repeat (3) step();
    check_eq("rst_level",   o_level,   0);
    check_eq("rst_edge",    o_edge,    0);
    check_eq("rst_pending", o_pending, 0);
    check_eq("rst_overrun", o_overrun, 0);
    check_eq("rst_any",     o_any,     0);
    rst = 1'b0;
    repeat (2) step();

    // Test 1: ch0 rise; the sampling edge is step 1, the pulse lands on step 6.
    i_signal[0] = 1'b1;
    step();
    for (int i = 2; i <= 5; i++) begin
      step();
      check_eq("t1_early_edge", o_edge[0], 0);
    end
    step();
    check_eq("t1_edge",    o_edge[0],    1);
    check_eq("t1_level",   o_level[0],   1);
    check_eq("t1_pending", o_pending[0], 1);
    check_eq("t1_any_lag", o_any,        0);
    step();
    check_eq("t1_edge_one_cycle", o_edge[0], 0);
    check_eq("t1_any",            o_any,     1);

    // Test 2: ch1 both; 3-cycle glitch rejected, 10-cycle pulse gives two edges.
    i_signal[1] = 1'b1;
    repeat (3) step();
    i_signal[1] = 1'b0;
    npulse = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (o_edge[1]) npulse++;
    end
    check_eq("t2_glitch_edges", npulse,     0);
    check_eq("t2_glitch_level", o_level[1], 0);
    i_signal[1] = 1'b1;
    npulse = 0; first_idx = -1; second_idx = -1;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (i == 10) i_signal[1] = 1'b0;
      if (o_edge[1]) begin
        npulse++;
        if (first_idx < 0) first_idx = i;
        else               second_idx = i;
      end
    end
    check_eq("t2_pulse_count", npulse,                 2);
    check_eq("t2_rise_at",     first_idx,              6);
    check_eq("t2_spacing",     second_idx - first_idx, 10);
    check_eq("t2_level_end",   o_level[1],             0);

    // Test 3: ch2 fall only.
    i_signal[2] = 1'b1;
    npulse = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (o_edge[2]) npulse++;
    end
    check_eq("t3_rise_edges",   npulse,       0);
    check_eq("t3_rise_level",   o_level[2],   1);
    check_eq("t3_rise_pending", o_pending[2], 0);
    i_signal[2] = 1'b0;
    npulse = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (o_edge[2]) npulse++;
    end
    check_eq("t3_fall_edges",   npulse,       1);
    check_eq("t3_fall_level",   o_level[2],   0);
    check_eq("t3_fall_pending", o_pending[2], 1);

    // Test 4: ch3 rise twice without clear -> overrun; then clear both flags.
    i_signal[3] = 1'b1;
    repeat (12) step();
    check_eq("t4_first_pending", o_pending[3], 1);
    check_eq("t4_first_overrun", o_overrun[3], 0);
    i_signal[3] = 1'b0;
    repeat (12) step();
    check_eq("t4_fall_no_overrun", o_overrun[3], 0);
    i_signal[3] = 1'b1;
    repeat (5) step();
    check_eq("t4_pre_overrun", o_overrun[3], 0);
    step();
    check_eq("t4_second_edge", o_edge[3],    1);
    check_eq("t4_overrun",     o_overrun[3], 1);
    repeat (3) step();
    i_clear[3] = 1'b1;
    step();
    i_clear[3] = 1'b0;
    check_eq("t4_clr_pending", o_pending[3], 0);
    check_eq("t4_clr_overrun", o_overrun[3], 0);

    // Test 5: clear on ch4 coinciding with a qualified edge while pending.
    i_signal[4] = 1'b1;
    repeat (12) step();
    i_signal[4] = 1'b0;
    repeat (12) step();
    check_eq("t5_pre_pending", o_pending[4], 1);
    i_signal[4] = 1'b1;
    repeat (5) step();
    i_clear[4] = 1'b1;
    step();
    i_clear[4] = 1'b0;
    check_eq("t5_edge",    o_edge[4],    1);
    check_eq("t5_pending", o_pending[4], 1);
    check_eq("t5_overrun", o_overrun[4], 0);
    step();
    check_eq("t5_pending_hold", o_pending[4], 1);
    check_eq("t5_overrun_hold", o_overrun[4], 0);

    // Test 6: reset with ch0 input high, rise reported after release.
    rst = 1'b1;
    repeat (3) step();
    check_eq("t6_rst_level",   o_level,   0);
    check_eq("t6_rst_edge",    o_edge,    0);
    check_eq("t6_rst_pending", o_pending, 0);
    check_eq("t6_rst_overrun", o_overrun, 0);
    check_eq("t6_rst_any",     o_any,     0);
    rst = 1'b0;
    npulse = 0; first_idx = -1;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (o_edge[0]) begin
        npulse++;
        if (first_idx < 0) first_idx = i;
      end
    end
    check_eq("t6_edge_count", npulse,       1);
    check_eq("t6_edge_at",    first_idx,    6);
    check_eq("t6_level",      o_level[0],   1);
    check_eq("t6_pending",    o_pending[0], 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
